// File: rtl/board_io_stepper_pkg.sv
// Shared constants for the board I/O stepper: active-low seven-segment codes
// and display source selections.
package board_io_stepper_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SEL_SIGN1 = 2'd0,
    SEL_SIGN2 = 2'd1,
    SEL_SIGN3 = 2'd2,
    SEL_SIGN4 = 2'd3
  } sel_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/board_io_stepper_btn_debounce.sv
// Button synchroniser and debouncer: a level change is accepted only after the
// synchronised input has differed from the current level for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = 20'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= 20'd0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/board_io_stepper.sv
// Board companion for the multi-cycle CPU: debounced single-step clock pulses
// and a 4-digit hex display of one of four debug words.
module board_io_stepper
  import board_io_stepper_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [7:0]  PULSE_CYCLES    = 8'd8,
  parameter logic [16:0] SCAN_DIV        = 17'd100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  sw_sel,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  output logic        cpu_clk,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {P_IDLE, P_LOW} pulse_e;

  logic        btn_level, btn_rise;
  pulse_e      pstate_q;
  logic [7:0]  pcnt_q;
  logic        cpu_clk_q;
  logic [16:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [15:0] sel_word;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .btn_i  (btn_step),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // Presses during an active pulse are dropped, not queued.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pstate_q  <= P_IDLE;
      pcnt_q    <= 8'd0;
      cpu_clk_q <= 1'b1;
    end else begin
      case (pstate_q)
        P_IDLE: if (btn_rise && btn_level) begin
          pstate_q  <= P_LOW;
          pcnt_q    <= PULSE_CYCLES - 8'd1;
          cpu_clk_q <= 1'b0;
        end
        default: if (pcnt_q == 8'd0) begin
          pstate_q  <= P_IDLE;
          cpu_clk_q <= 1'b1;
        end else begin
          pcnt_q <= pcnt_q - 8'd1;
        end
      endcase
    end
  end

  always_comb begin
    case (sel_e'(sw_sel))
      SEL_SIGN1: sel_word = sign1;
      SEL_SIGN2: sel_word = sign2;
      SEL_SIGN3: sel_word = sign3;
      default:   sel_word = sign4;
    endcase
  end

  // The displayed word only changes at a frame boundary so a frame never tears.
  always_comb begin
    scan_d = scan_q + 17'd1;
    idx_d  = idx_q;
    word_d = word_q;
    if (scan_q == SCAN_DIV - 17'd1) begin
      scan_d = 17'd0;
      idx_d  = idx_q + 2'd1;
      if (idx_q == 2'd3) word_d = sel_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      scan_q <= 17'd0;
      idx_q  <= 2'd0;
      word_q <= 16'h0000;
      an_q   <= 4'hF;
      seg_q  <= SEG_BLANK;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      word_q <= word_d;
      an_q   <= ~(4'b0001 << idx_q);
      seg_q  <= hex_to_seg(word_q[{idx_q, 2'b00} +: 4]);
    end
  end

  assign cpu_clk = cpu_clk_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = 1'b1;

endmodule
